// File: rtl/mux_rr_arbiter_if.sv
// Two-requester channel bundle for mux_rr_arbiter: requester request/data,
// grants and mux select, and the muxed output channel with its ready.
// Optional lock inputs are present only when ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef ARB_LOCK_EN
    logic             lock_a;
    logic             lock_b;

    // requesters + downstream side
    modport master (
        output req_a, data_a, req_b, data_b, out_ready, lock_a, lock_b,
        input  gnt_a, gnt_b, sel, out_valid, out_data
    );

    // arbiter side
    modport slave (
        input  req_a, data_a, req_b, data_b, out_ready, lock_a, lock_b,
        output gnt_a, gnt_b, sel, out_valid, out_data
    );
`else
    // requesters + downstream side
    modport master (
        output req_a, data_a, req_b, data_b, out_ready,
        input  gnt_a, gnt_b, sel, out_valid, out_data
    );

    // arbiter side
    modport slave (
        input  req_a, data_a, req_b, data_b, out_ready,
        output gnt_a, gnt_b, sel, out_valid, out_data
    );
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-way round-robin arbiter with integrated output mux.
// The owner keeps the channel until it drops req, or until the other side is
// waiting and the owner has moved HOLD_MAX beats in this tenure. Release hands
// over directly to a waiting competitor with no idle bubble.
// Optional feature macro: ARB_LOCK_EN -- adds lock_a/lock_b; while the owner's
// lock is high only a dropped req ends its tenure.
module mux_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux_rr_arbiter_if.slave   bus
);
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic          sel_q, sel_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_next;
    logic          beat;
    logic          lock_own;

    // output channel: combinational mux and valid qualified by the live req
    assign bus.out_data  = sel_q ? bus.data_b : bus.data_a;
    assign bus.out_valid = (gnt_a_q & bus.req_a) | (gnt_b_q & bus.req_b);
    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.sel       = sel_q;

    assign beat = bus.out_valid & bus.out_ready;

    // beats in this tenure, saturating so an uncontested owner never wraps
    assign cnt_next = (beat && (cnt_q != HOLD_C)) ? cnt_q + CW'(1) : cnt_q;

    // current owner's lock request (tied off when the feature is absent)
`ifdef ARB_LOCK_EN
    always_comb begin
        lock_own = 1'b0;
        if (state_q == OWN_A) lock_own = bus.lock_a;
        if (state_q == OWN_B) lock_own = bus.lock_b;
    end
`else
    assign lock_own = 1'b0;
`endif

    // next-state: entry from IDLE by priority, release/handover while owned
    always_comb begin
        logic mine_req;
        logic other_req;
        state_d   = state_q;
        prio_d    = prio_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        mine_req  = 1'b0;
        other_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || !prio_q)) begin
                    state_d = OWN_A;
                    sel_d   = 1'b0;
                    cnt_d   = '0;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                    sel_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            OWN_A, OWN_B: begin
                mine_req  = (state_q == OWN_A) ? bus.req_a : bus.req_b;
                other_req = (state_q == OWN_A) ? bus.req_b : bus.req_a;
                if (!mine_req || (other_req && (cnt_next >= HOLD_C) && !lock_own)) begin
                    // the side that did not just own gets priority next time
                    prio_d = (state_q == OWN_A);
                    cnt_d  = '0;
                    if (other_req) begin
                        state_d = (state_q == OWN_A) ? OWN_B : OWN_A;
                        sel_d   = (state_q == OWN_A);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_next;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
